// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: fetches one instruction word per control-unit handshake,
// decodes it, and applies the captured jump/branch outcome to the PC before the next fetch.
module instruction_fetch_decode #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          INSTR_WIDTH = 16,
  parameter int unsigned PC_RESET    = 0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read_instruction,
  input  logic                   jump_execute,
  input  logic                   branch_taken,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   decode_complete,
  output logic [3:0]             opcode,
  output logic [2:0]             field_a,
  output logic [2:0]             field_b,
  output logic [5:0]             imm,
  output logic [ADDR_WIDTH-1:0]  jump_target,
  output logic                   fetch_error
);

  localparam int                    CW          = $clog2(MEM_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT     = ADDR_WIDTH'(PC_RESET);
  localparam logic [CW-1:0]         TIMEOUT_CNT = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_DONE,
    S_EXEC,
    S_UPDATE
  } state_e;

  state_e                 state_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic [ADDR_WIDTH-1:0]  jump_target_q;
  logic [ADDR_WIDTH-1:0]  imm_sext;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   jflag_q;
  logic                   bflag_q;
  logic                   imem_req_q;
  logic                   decode_complete_q;
  logic                   fetch_error_q;
  logic [3:0]             opcode_q;
  logic [2:0]             field_a_q;
  logic [2:0]             field_b_q;
  logic [5:0]             imm_q;

  // Branch offset is a 6-bit signed immediate resized to the PC width.
  if (ADDR_WIDTH > 6) begin : g_sext_wide
    assign imm_sext = {{(ADDR_WIDTH-6){imm_q[5]}}, imm_q};
  end else if (ADDR_WIDTH == 6) begin : g_sext_equal
    assign imm_sext = imm_q;
  end else begin : g_sext_narrow
    assign imm_sext = imm_q[ADDR_WIDTH-1:0];
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    pc_d  = pc_q + ADDR_WIDTH'(1);
    if (jflag_q) begin
      pc_d = jump_target_q;
    end else if (bflag_q) begin
      pc_d = pc_q + ADDR_WIDTH'(1) + imm_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      pc_q              <= PC_INIT;
      instr_q           <= '0;
      cnt_q             <= '0;
      jflag_q           <= 1'b0;
      bflag_q           <= 1'b0;
      imem_req_q        <= 1'b0;
      decode_complete_q <= 1'b0;
      fetch_error_q     <= 1'b0;
      opcode_q          <= '0;
      field_a_q         <= '0;
      field_b_q         <= '0;
      imm_q             <= '0;
      jump_target_q     <= '0;
    end else begin
      imem_req_q    <= 1'b0;
      fetch_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (read_instruction) begin
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          cnt_q   <= '0;
          state_q <= read_instruction ? S_WAIT_MEM : S_IDLE;
        end
        // Abort beats a response; a response beats a timeout in the same cycle.
        S_WAIT_MEM: begin
          if (!read_instruction) begin
            state_q <= S_IDLE;
          end else if (imem_valid) begin
            instr_q <= imem_rdata;
            state_q <= S_DECODE;
          end else if (cnt_d == TIMEOUT_CNT) begin
            fetch_error_q <= 1'b1;
            imem_req_q    <= 1'b1;
            state_q       <= S_FETCH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DECODE: begin
          if (!read_instruction) begin
            state_q <= S_IDLE;
          end else begin
            opcode_q          <= instr_q[15:12];
            field_a_q         <= instr_q[11:9];
            field_b_q         <= instr_q[8:6];
            imm_q             <= instr_q[5:0];
            jump_target_q     <= instr_q[ADDR_WIDTH-1:0];
            decode_complete_q <= 1'b1;
            state_q           <= S_DONE;
          end
        end
        S_DONE: begin
          if (!read_instruction) begin
            decode_complete_q <= 1'b0;
            jflag_q           <= 1'b0;
            bflag_q           <= 1'b0;
            state_q           <= S_EXEC;
          end
        end
        S_EXEC: begin
          jflag_q <= jflag_q | jump_execute;
          bflag_q <= bflag_q | branch_taken;
          if (read_instruction) begin
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pc_q       <= pc_d;
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req        = imem_req_q;
  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign decode_complete = decode_complete_q;
  assign opcode          = opcode_q;
  assign field_a         = field_a_q;
  assign field_b         = field_b_q;
  assign imm             = imm_q;
  assign jump_target     = jump_target_q;
  assign fetch_error     = fetch_error_q;

endmodule
